// File: rtl/aes_enc_core_if.sv
// aes_enc_core_if: handshake, key-store and status signals of aes_enc_core
// Signals: in_valid/in_ready/pt  plaintext handshake
//          out_valid/out_ready/ct ciphertext handshake
//          rk_idx/rk              round-key lookup into the external key store
//          busy                   core is in ROUND or DONE
// Modports: slave = core side, master = producer/consumer/key-store side.
interface aes_enc_core_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] pt;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ct;
    logic         busy;
    modport slave (
        input  in_valid, pt, rk, out_ready,
        output in_ready, rk_idx, out_valid, ct, busy
    );
    modport master (
        output in_valid, pt, rk, out_ready,
        input  in_ready, rk_idx, out_valid, ct, busy
    );
endinterface

// File: rtl/aes_enc_core.sv
// aes_enc_core: iterative AES-128 encryption, one cipher round per clock over a shared datapath
// Ports: clk    rising-edge clock
//        rst_n  asynchronous active-low reset
//        bus    aes_enc_core_if.slave: pt in over in_valid/in_ready, ct out over out_valid/out_ready,
//               rk_idx selects the round key that the external store returns on rk in the same cycle,
//               busy is high in ROUND and DONE.
// aes_sbox: forward AES S-box, one byte in, one byte out.
module aes_sbox (
    input  logic [7:0] i_a,
    output logic [7:0] o_y
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    // entry a starts at bit 2047-8a, which is {~a, 3'b111}
    assign o_y = SBOX[{~i_a, 3'b111} -: 8];
endmodule

module aes_enc_core #(
    parameter int NR = 10
) (
    input logic           clk,
    input logic           rst_n,
    aes_enc_core_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
    state_t       r_fsm;
    state_t       w_fsm_nxt;
    logic [127:0] r_state_q;
    logic [3:0]   r_round_q;
    logic [127:0] w_sb;
    logic [127:0] w_sr;
    logic [127:0] w_mc;
    logic [127:0] w_next;
    logic         w_last;
    logic         w_accept;
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction
    for (genvar i = 0; i < 16; i++) begin : g_sb
        aes_sbox u_sb (.i_a(r_state_q[127-8*i -: 8]), .o_y(w_sb[127-8*i -: 8]));
    end
    // byte 4c+r: ShiftRows takes row r from column (c+r) mod 4;
    // MixColumns row r is 2*a[r] ^ 3*a[r+1] ^ a[r+2] ^ a[r+3], indices mod 4
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int B0 = 127 - 8 * (4 * c + r);
            localparam int B1 = 127 - 8 * (4 * c + (r + 1) % 4);
            localparam int B2 = 127 - 8 * (4 * c + (r + 2) % 4);
            localparam int B3 = 127 - 8 * (4 * c + (r + 3) % 4);
            localparam int BS = 127 - 8 * (4 * ((c + r) % 4) + r);
            assign w_sr[B0 -: 8] = w_sb[BS -: 8];
            assign w_mc[B0 -: 8] = xt(w_sr[B0 -: 8]) ^ xt(w_sr[B1 -: 8]) ^ w_sr[B1 -: 8]
                                 ^ w_sr[B2 -: 8] ^ w_sr[B3 -: 8];
        end
    end
    assign w_last   = r_round_q == 4'(NR);
    assign w_accept = r_fsm == IDLE && bus.in_valid;
    // the final round bypasses MixColumns
    assign w_next   = (w_last ? w_sr : w_mc) ^ bus.rk;
    always_comb begin
        w_fsm_nxt = r_fsm;
        if (w_accept)
            w_fsm_nxt = ROUND;
        else if (r_fsm == ROUND && w_last)
            w_fsm_nxt = DONE;
        else if (r_fsm == DONE && bus.out_ready)
            w_fsm_nxt = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm     <= IDLE;
            r_state_q <= '0;
            r_round_q <= '0;
        end else begin
            r_fsm <= w_fsm_nxt;
            if (w_accept) begin
                r_state_q <= bus.pt ^ bus.rk;
                r_round_q <= 4'd1;
            end else if (r_fsm == ROUND) begin
                r_state_q <= w_next;
                r_round_q <= w_last ? r_round_q : r_round_q + 4'd1;
            end
        end
    end
    // all outputs decode registered state only
    assign bus.in_ready  = r_fsm == IDLE;
    assign bus.out_valid = r_fsm == DONE;
    assign bus.busy      = r_fsm != IDLE;
    assign bus.rk_idx    = r_fsm == ROUND ? r_round_q : 4'd0;
    assign bus.ct        = r_state_q;
endmodule

// File: tb/tb_aes_enc_core.sv
// tb_aes_enc_core: directed FIPS-197 vectors, handshake timing, stall, mid-round reset and back-to-back blocks
module tb_aes_enc_core;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    // zero key schedule, pt byte i = i: state after round 1 worked out by hand
    localparam logic [127:0] PZ = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] R1Z = 128'h6a6a5c452c6d3351b0d95d61279c215c;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] rks [16];
    logic [7:0]   sb [256];
    int           n_tests = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           acc_cyc = 0;
    aes_enc_core_if bus();
    aes_enc_core dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign bus.rk = rks[bus.rk_idx];
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction
    // S-box from the GF(2^8) inverse and affine map, used only for the key schedule
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask
    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rks[r] = r <= 10 ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // returns #1 after the accepting edge, then scrambles pt
    task automatic send(input string tag, input logic [127:0] p);
        int k;
        k = 0;
        bus.pt = p;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && k < 40) begin
            tick();
            k++;
        end
        chk({tag, "_accept_wait"}, 128'(k < 40), 128'd1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        bus.in_valid = 1'b0;
        bus.pt = ~p;
    endtask
    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (!bus.out_valid && k < 40) begin
            tick();
            k++;
        end
        chk({tag, "_out_wait"}, 128'(k < 40), 128'd1);
    endtask
    initial begin
        int n;
        int bad;
        int a0;
        logic [43:0] seq;
        bus.in_valid = 1'b0;
        bus.pt = '0;
        bus.out_ready = 1'b0;
        build_sbox();
        expand(K1);
        #2;
        chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
        chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_busy", 128'(bus.busy), 128'd0);
        chk("rst_rk_idx", 128'(bus.rk_idx), 128'd0);
        chk("rst_ct", bus.ct, 128'd0);
        #10;
        rst_n = 1'b1;
        tick();
        // FIPS key 000102..0f, latency counted with the accepting edge as edge 1
        send("t1", P1);
        n = 1;
        while (!bus.out_valid && n < 30) begin
            tick();
            n++;
        end
        chk("t1_latency", 128'(n), 128'd11);
        chk("t1_ct", bus.ct, C1);
        // hold out_ready low, toss in_valid pulses at the core
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = k[0];
            bus.pt = P2;
            tick();
            if (!bus.out_valid || bus.ct !== C1 || bus.in_ready || !bus.busy) bad++;
        end
        chk("t3_stall_hold", 128'(bad), 128'd0);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("t3_idle_after", 128'({bus.in_ready, bus.out_valid, bus.busy}), 128'b100);
        tick();
        chk("t3_pulses_ignored", 128'(bus.busy), 128'd0);
        // FIPS key 2b7e.., rk_idx 0..10 on successive cycles
        expand(K2);
        seq = '0;
        seq[43:40] = bus.rk_idx;
        send("t2", P2);
        for (int r = 1; r <= 10; r++) begin
            seq[43-4*r -: 4] = bus.rk_idx;
            tick();
        end
        chk("t2_rk_seq", 128'(seq), 128'(44'h0123456789a));
        chk("t2_out_valid", 128'(bus.out_valid), 128'd1);
        chk("t2_done_rk_idx", 128'(bus.rk_idx), 128'd0);
        chk("t2_ct", bus.ct, C2);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        // reset while round_q is 5
        send("t4a", P2);
        repeat (4) tick();
        chk("t4_round5", 128'(dut.r_round_q), 128'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4_rst_flags", 128'({bus.in_ready, bus.out_valid, bus.busy}), 128'b100);
        chk("t4_rst_rk_idx", 128'(bus.rk_idx), 128'd0);
        chk("t4_rst_round_q", 128'(dut.r_round_q), 128'd0);
        chk("t4_rst_state_q", dut.r_state_q, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (bus.out_valid || bus.busy) bad++;
        end
        chk("t4_no_spurious", 128'(bad), 128'd0);
        send("t4b", P2);
        wait_valid("t4b");
        chk("t4_fresh_ct", bus.ct, C2);
        bus.out_ready = 1'b1;
        tick();
        // back-to-back with out_ready high; key store swapped while the first block is in DONE
        expand(K1);
        send("t5a", P1);
        a0 = acc_cyc;
        wait_valid("t5a");
        chk("t5_ct_a", bus.ct, C1);
        expand(K2);
        send("t5b", P2);
        chk("t5_spacing", 128'(acc_cyc - a0), 128'd12);
        wait_valid("t5b");
        chk("t5_ct_b", bus.ct, C2);
        tick();
        // zero key schedule exposes the raw round-1 transform
        for (int r = 0; r < 16; r++) rks[r] = '0;
        send("t6", PZ);
        tick();
        chk("t6_round1_state", dut.r_state_q, R1Z);
        wait_valid("t6");
        tick();
        chk("t6_back_idle", 128'(bus.in_ready), 128'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
